// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port unified memory. Data accesses win
// over instruction fetches. Each access holds the memory for LATENCY cycles,
// then pulses the owner's done for one cycle with the read data captured.
module mem_arbiter #(
   parameter int unsigned LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic [15:0] if_rdata,
   output logic        if_done,
   output logic        if_stall,
   input  logic        dm_re,
   input  logic        dm_we,
   input  logic [15:0] dm_addr,
   input  logic [15:0] dm_wdata,
   output logic [15:0] dm_rdata,
   output logic        dm_done,
   output logic        dm_stall,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [15:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm} state_e;

   localparam logic [3:0] LastCnt = 4'(LATENCY - 1);

   state_e      r_state;
   logic [3:0]  r_cnt;
   logic        r_owner_dm;   // grant owner: 1 = data port, 0 = fetch port
   logic        r_write;      // latched op of the current data access
   logic [15:0] r_mem_addr;
   logic [15:0] r_mem_wdata;
   logic        r_mem_re;
   logic        r_mem_we;
   logic        r_if_done;
   logic        r_dm_done;
   logic [15:0] r_if_rdata;
   logic [15:0] r_dm_rdata;

   logic        w_done_q;
   logic        w_dm_req;

   assign w_done_q = r_if_done | r_dm_done;
   assign w_dm_req = dm_re | dm_we;

   // Arbitration FSM; memory-side outputs are registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_cnt       <= 4'd0;
         r_owner_dm  <= 1'b0;
         r_write     <= 1'b0;
         r_mem_addr  <= 16'd0;
         r_mem_wdata <= 16'd0;
         r_mem_re    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_if_done   <= 1'b0;
         r_dm_done   <= 1'b0;
         r_if_rdata  <= 16'd0;
         r_dm_rdata  <= 16'd0;
      end else begin
         r_if_done <= 1'b0;
         r_dm_done <= 1'b0;
         case (r_state)
            StIdle: begin
               // A request still held during its own done cycle must not re-grant.
               if (!w_done_q) begin
                  if (w_dm_req) begin
                     r_state     <= StBusyDm;
                     r_owner_dm  <= 1'b1;
                     r_write     <= dm_we;
                     r_cnt       <= 4'd0;
                     r_mem_addr  <= dm_addr;
                     r_mem_wdata <= dm_wdata;
                     r_mem_re    <= ~dm_we;
                     r_mem_we    <= dm_we && (LastCnt == 4'd0);
                  end else if (if_req) begin
                     r_state     <= StBusyIf;
                     r_owner_dm  <= 1'b0;
                     r_write     <= 1'b0;
                     r_cnt       <= 4'd0;
                     r_mem_addr  <= if_addr;
                     r_mem_wdata <= 16'd0;
                     r_mem_re    <= 1'b1;
                     r_mem_we    <= 1'b0;
                  end
               end
            end
            StBusyIf, StBusyDm: begin
               if (r_cnt == LastCnt) begin
                  if (r_owner_dm) begin
                     r_dm_rdata <= mem_rdata;
                     r_dm_done  <= 1'b1;
                  end else begin
                     r_if_rdata <= mem_rdata;
                     r_if_done  <= 1'b1;
                  end
                  r_state     <= StIdle;
                  r_cnt       <= 4'd0;
                  r_mem_addr  <= 16'd0;
                  r_mem_wdata <= 16'd0;
                  r_mem_re    <= 1'b0;
                  r_mem_we    <= 1'b0;
               end else begin
                  r_cnt    <= r_cnt + 4'd1;
                  // Single write strobe lands on the final access cycle.
                  r_mem_we <= r_write && ((r_cnt + 4'd1) == LastCnt);
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_re    = r_mem_re;
   assign mem_we    = r_mem_we;
   assign if_rdata  = r_if_rdata;
   assign dm_rdata  = r_dm_rdata;
   assign if_done   = r_if_done;
   assign dm_done   = r_dm_done;
   assign if_stall  = if_req & ~r_if_done;
   assign dm_stall  = w_dm_req & ~r_dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed literal checks, then randomized traffic
// checked every cycle against a timeline model of the arbiter.
module tb_mem_arbiter;

   localparam int Lat = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = 16'd0;
   logic [15:0] if_rdata;
   logic        if_done, if_stall;
   logic        dm_re = 1'b0, dm_we = 1'b0;
   logic [15:0] dm_addr = 16'd0, dm_wdata = 16'd0;
   logic [15:0] dm_rdata;
   logic        dm_done, dm_stall;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_re, mem_we;

   // LATENCY=1 instance
   logic        if_req1 = 1'b0;
   logic [15:0] if_addr1 = 16'd0;
   logic [15:0] if_rdata1;
   logic        if_done1, if_stall1;
   logic        dm_re1 = 1'b0, dm_we1 = 1'b0;
   logic [15:0] dm_addr1 = 16'd0, dm_wdata1 = 16'd0;
   logic [15:0] dm_rdata1;
   logic        dm_done1, dm_stall1;
   logic [15:0] mem_addr1, mem_wdata1, mem_rdata1;
   logic        mem_re1, mem_we1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] env_mem [0:255];

   // model state
   int          m_owner = 0;  // 0 none, 1 fetch, 2 data
   int          m_start = 0;
   logic [15:0] m_addr = 16'd0, m_wdata = 16'd0;
   logic        m_write = 1'b0;
   logic        m_if_done = 1'b0, m_dm_done = 1'b0;
   logic [15:0] m_if_rdata = 16'd0, m_dm_rdata = 16'd0;
   logic [15:0] m_mem [0:255];
   int          edge_n = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.LATENCY(Lat)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_done(if_done), .if_stall(if_stall),
      .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re),
      .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1),
      .if_done(if_done1), .if_stall(if_stall1),
      .dm_re(dm_re1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
      .dm_rdata(dm_rdata1), .dm_done(dm_done1), .dm_stall(dm_stall1),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_re(mem_re1),
      .mem_we(mem_we1), .mem_rdata(mem_rdata1)
   );

   function automatic logic [15:0] init_val(input int i);
      if (i == 16) return 16'hA5A5;
      return 16'(i * 40503) ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] rand_addr();
      return 16'($urandom_range(31, 0));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // memory behind the arbiter: combinational read, write on the clock edge
   assign mem_rdata  = env_mem[mem_addr[7:0]];
   assign mem_rdata1 = mem_addr1 ^ 16'hC3C3;

   initial begin
      for (int i = 0; i < 256; i++) env_mem[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (mem_we) env_mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   // Timeline model: an access granted at edge S owns memory through edge S+Lat,
   // completes there, and the following done cycle blocks any new grant.
   initial begin
      for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
      forever begin
         logic prev_done;
         @(posedge clk);
         edge_n++;
         if (rst) begin
            m_owner = 0; m_if_done = 1'b0; m_dm_done = 1'b0;
            m_if_rdata = 16'd0; m_dm_rdata = 16'd0;
         end else begin
            prev_done = m_if_done | m_dm_done;
            m_if_done = 1'b0;
            m_dm_done = 1'b0;
            if (m_owner != 0) begin
               if (edge_n - m_start == Lat) begin
                  if (m_owner == 1) begin
                     m_if_rdata = m_mem[m_addr[7:0]];
                     m_if_done  = 1'b1;
                  end else begin
                     m_dm_rdata = m_mem[m_addr[7:0]];
                     m_dm_done  = 1'b1;
                     if (m_write) m_mem[m_addr[7:0]] = m_wdata;
                  end
                  m_owner = 0;
               end
            end else if (!prev_done) begin
               if (dm_re || dm_we) begin
                  m_owner = 2; m_start = edge_n; m_addr = dm_addr;
                  m_wdata = dm_wdata; m_write = dm_we;
               end else if (if_req) begin
                  m_owner = 1; m_start = edge_n; m_addr = if_addr;
                  m_wdata = 16'd0; m_write = 1'b0;
               end
            end
         end
      end
   end

   // per-cycle compare on the falling edge
   initial begin
      forever begin
         logic        e_busy, e_ifd, e_dmd, e_re, e_we;
         logic [15:0] e_addr, e_wdata, e_ifr, e_dmr;
         @(negedge clk);
         e_busy  = !rst && (m_owner != 0);
         e_ifd   = !rst && m_if_done;
         e_dmd   = !rst && m_dm_done;
         e_re    = e_busy && !m_write;
         e_we    = e_busy && (m_owner == 2) && m_write && (edge_n - m_start == Lat - 1);
         e_addr  = e_busy ? m_addr : 16'd0;
         e_wdata = (e_busy && m_owner == 2) ? m_wdata : 16'd0;
         e_ifr   = rst ? 16'd0 : m_if_rdata;
         e_dmr   = rst ? 16'd0 : m_dm_rdata;
         check("if_done", 32'(if_done), 32'(e_ifd));
         check("dm_done", 32'(dm_done), 32'(e_dmd));
         check("if_rdata", 32'(if_rdata), 32'(e_ifr));
         check("dm_rdata", 32'(dm_rdata), 32'(e_dmr));
         check("mem_addr", 32'(mem_addr), 32'(e_addr));
         check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
         check("mem_re", 32'(mem_re), 32'(e_re));
         check("mem_we", 32'(mem_we), 32'(e_we));
         check("if_stall", 32'(if_stall), 32'(if_req & ~e_ifd));
         check("dm_stall", 32'(dm_stall), 32'((dm_re | dm_we) & ~e_dmd));
         check("done_excl", 32'(if_done & dm_done), 32'd0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Counts ticks from the drive point until the port's done is seen (-1 on timeout).
   task automatic wait_done(input bit dm, output int cyc, output int re_n, output int we_n);
      cyc = 0; re_n = 0; we_n = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         cyc++;
         if (mem_re) re_n++;
         if (mem_we) we_n++;
         if (dm ? dm_done : if_done) return;
      end
      cyc = -1;
   endtask

   task automatic new_dm_op();
      int op;
      op       = int'($urandom_range(2, 0));
      dm_re    = (op != 1);
      dm_we    = (op != 0);
      dm_addr  = rand_addr();
      dm_wdata = 16'($urandom);
   endtask

   initial begin
      int  cyc, re_n, we_n, cyc2;
      bit  got;
      tick();
      tick();
      check("rst_if_rdata", 32'(if_rdata), 32'd0);
      check("rst_mem_re", 32'(mem_re), 32'd0);
      rst = 1'b0;
      tick();

      // fetch read of preloaded word
      if_req = 1'b1; if_addr = 16'h0010;
      wait_done(1'b0, cyc, re_n, we_n);
      check("fetch_done_cycle", 32'(cyc), 32'd5);
      check("fetch_re_cycles", 32'(re_n), 32'd4);
      check("fetch_rdata", 32'(if_rdata), 32'hA5A5);
      check("fetch_stall_at_done", 32'(if_stall), 32'd0);
      if_req = 1'b0;
      tick(); tick();

      // data write then read back
      dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
      wait_done(1'b1, cyc, re_n, we_n);
      check("write_done_cycle", 32'(cyc), 32'd5);
      check("write_we_cycles", 32'(we_n), 32'd1);
      check("write_re_cycles", 32'(re_n), 32'd0);
      dm_we = 1'b0;
      tick(); tick();
      dm_re = 1'b1;
      wait_done(1'b1, cyc, re_n, we_n);
      check("readback_data", 32'(dm_rdata), 32'h1234);
      check("readback_re_cycles", 32'(re_n), 32'd4);
      dm_re = 1'b0;
      tick(); tick();

      // simultaneous requests: data first, then fetch, then held fetch again
      if_req = 1'b1; if_addr = 16'h0010;
      dm_re = 1'b1; dm_addr = 16'h0020;
      wait_done(1'b1, cyc, re_n, we_n);
      check("simul_dm_done_cycle", 32'(cyc), 32'd5);
      check("simul_if_stall", 32'(if_stall), 32'd1);
      check("simul_if_not_done", 32'(if_done), 32'd0);
      dm_re = 1'b0;
      wait_done(1'b0, cyc2, re_n, we_n);
      check("simul_if_done_cycle", 32'(cyc + cyc2), 32'd11);
      check("simul_if_rdata", 32'(if_rdata), 32'hA5A5);
      wait_done(1'b0, cyc2, re_n, we_n);
      check("held_fetch_spacing", 32'(cyc2), 32'd6);
      if_req = 1'b0;
      tick(); tick();

      // reset in the middle of a write
      dm_we = 1'b1; dm_addr = 16'h0030; dm_wdata = 16'hBEEF;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("abort_no_we_before", 32'(mem_we), 32'd0);
      end
      rst = 1'b1;
      #1;
      check("async_mem_re", 32'(mem_re), 32'd0);
      check("async_mem_addr", 32'(mem_addr), 32'd0);
      check("async_mem_wdata", 32'(mem_wdata), 32'd0);
      check("async_dm_rdata", 32'(dm_rdata), 32'd0);
      check("async_if_rdata", 32'(if_rdata), 32'd0);
      tick();
      tick();
      check("abort_mem_kept", 32'(env_mem[8'h30]), 32'(init_val(48)));
      rst = 1'b0;
      wait_done(1'b1, cyc, re_n, we_n);
      check("reserve_done_cycle", 32'(cyc), 32'd5);
      check("reserve_we_cycles", 32'(we_n), 32'd1);
      check("reserve_mem_written", 32'(env_mem[8'h30]), 32'hBEEF);
      dm_we = 1'b0;
      tick(); tick();

      // LATENCY=1 instance
      if_req1 = 1'b1; if_addr1 = 16'h0044;
      cyc = 0; re_n = 0; got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         cyc++;
         if (mem_re1) re_n++;
         got = if_done1;
      end
      check("lat1_read_done_cycle", 32'(cyc), 32'd2);
      check("lat1_read_re_cycles", 32'(re_n), 32'd1);
      check("lat1_read_rdata", 32'(if_rdata1), 32'hC387);
      check("lat1_read_stall", 32'(if_stall1), 32'd0);
      if_req1 = 1'b0;
      tick(); tick();
      dm_we1 = 1'b1; dm_addr1 = 16'h0005; dm_wdata1 = 16'h7777;
      cyc = 0; we_n = 0; got = 1'b0; cyc2 = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         cyc++;
         if (mem_we1) begin
            we_n++;
            cyc2 = int'(mem_wdata1);
         end
         got = dm_done1;
      end
      check("lat1_write_done_cycle", 32'(cyc), 32'd2);
      check("lat1_write_we_cycles", 32'(we_n), 32'd1);
      check("lat1_write_wdata", 32'(cyc2), 32'h7777);
      check("lat1_write_rdata", 32'(dm_rdata1), 32'hC3C6);
      check("lat1_write_stall", 32'(dm_stall1), 32'd0);
      dm_we1 = 1'b0;
      tick(); tick();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (if_req) begin
            if (m_if_done) begin
               if ($urandom_range(1, 0) == 1) if_addr = rand_addr();
               else if_req = 1'b0;
            end else if (m_owner == 1 && $urandom_range(3, 0) == 0) begin
               if_addr = rand_addr();
            end
         end else if ($urandom_range(2, 0) == 0) begin
            if_req = 1'b1;
            if_addr = rand_addr();
         end
         if (dm_re || dm_we) begin
            if (m_dm_done) begin
               if ($urandom_range(1, 0) == 1) new_dm_op();
               else begin
                  dm_re = 1'b0;
                  dm_we = 1'b0;
               end
            end else if (m_owner == 2 && $urandom_range(3, 0) == 0) begin
               new_dm_op();
            end
         end else if ($urandom_range(2, 0) == 0) begin
            new_dm_op();
         end
         if ($urandom_range(199, 0) == 0) begin
            rst = 1'b1;
            tick();
            tick();
            rst = 1'b0;
         end
      end
      if_req = 1'b0; dm_re = 1'b0; dm_we = 1'b0;
      for (int c = 0; c < 12; c++) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
